// File: rtl/vga_timing_pkg.sv
// Shared raster constants, region encoding and axis boundary helpers for vga_timing_gen.
package vga_timing_pkg;

  // 640x480 @ 60 Hz
  localparam int unsigned DefHActive = 640;
  localparam int unsigned DefHFp     = 16;
  localparam int unsigned DefHSync   = 96;
  localparam int unsigned DefHBp     = 48;
  localparam int unsigned DefVActive = 480;
  localparam int unsigned DefVFp     = 10;
  localparam int unsigned DefVSync   = 2;
  localparam int unsigned DefVBp     = 33;
  localparam int unsigned DefCntW    = 10;

  localparam bit PolActiveLow  = 1'b0;
  localparam bit PolActiveHigh = 1'b1;

  typedef enum logic [1:0] {
    RegActive,
    RegFrontPorch,
    RegSync,
    RegBackPorch
  } region_e;

  function automatic int unsigned axis_total(input int unsigned active, input int unsigned fp,
                                             input int unsigned sync, input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int unsigned sync_first(input int unsigned active, input int unsigned fp);
    return active + fp;
  endfunction

  function automatic int unsigned back_porch_first(input int unsigned active,
                                                   input int unsigned fp,
                                                   input int unsigned sync);
    return active + fp + sync;
  endfunction

  function automatic region_e region_of(input int unsigned pos, input int unsigned active,
                                        input int unsigned fp, input int unsigned sync);
    region_e r;
    if (pos < active) begin
      r = RegActive;
    end else if (pos < sync_first(active, fp)) begin
      r = RegFrontPorch;
    end else if (pos < back_porch_first(active, fp, sync)) begin
      r = RegSync;
    end else begin
      r = RegBackPorch;
    end
    return r;
  endfunction

endpackage

// File: rtl/vga_axis_timer.sv
// One raster axis: enabled wrap counter with registered sync level and a next-state active flag.
module vga_axis_timer
  import vga_timing_pkg::*;
#(
  parameter int unsigned ACTIVE = 1,
  parameter int unsigned FP     = 0,
  parameter int unsigned SYNC   = 1,
  parameter int unsigned BP     = 0,
  parameter bit          POL    = PolActiveLow,
  parameter int unsigned CNT_W  = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             adv,
  input  logic             restart,
  output logic [CNT_W-1:0] count,
  output logic             sync,
  output logic             last,
  output logic             active_nxt
);

  localparam int unsigned      Total   = axis_total(ACTIVE, FP, SYNC, BP);
  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(Total - 1);

  logic [CNT_W-1:0] count_d, count_q;
  logic             sync_d, sync_q;
  region_e          region_d;

  assign last = (count_q == LastCnt);

  always_comb begin
    count_d = count_q;
    if (restart) begin
      count_d = LastCnt;
    end else if (adv) begin
      count_d = last ? '0 : count_q + 1'b1;
    end
  end

  // Decode from the next count so the registered level lines up with the registered count.
  always_comb begin
    region_d   = region_of(32'(count_d), ACTIVE, FP, SYNC);
    active_nxt = (region_d == RegActive);
    sync_d     = (region_d == RegSync) ? POL : ~POL;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= LastCnt;
      sync_q  <= ~POL;
    end else begin
      count_q <= count_d;
      sync_q  <= sync_d;
    end
  end

  assign count = count_q;
  assign sync  = sync_q;

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator advancing on a pixel-enable strobe.
// Optional 16-bit frame counter output when VGA_TIMING_FRAME_CNT_EN is defined.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DefHActive,
  parameter int unsigned H_FP     = DefHFp,
  parameter int unsigned H_SYNC   = DefHSync,
  parameter int unsigned H_BP     = DefHBp,
  parameter int unsigned V_ACTIVE = DefVActive,
  parameter int unsigned V_FP     = DefVFp,
  parameter int unsigned V_SYNC   = DefVSync,
  parameter int unsigned V_BP     = DefVBp,
  parameter bit          HS_POL   = PolActiveLow,
  parameter bit          VS_POL   = PolActiveLow,
  parameter int unsigned CNT_W    = DefCntW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_pix_en,
  input  logic             i_restart,
  output logic [CNT_W-1:0] o_hcounter,
  output logic [CNT_W-1:0] o_vcounter,
  output logic             o_hsync,
  output logic             o_vsync,
  output logic             o_active,
  output logic             o_line_start,
  output logic             o_frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
  ,
  output logic [15:0]      o_frame_cnt
`endif
);

  localparam int unsigned     HTotal   = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned     VTotal   = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam longint unsigned CntRange = 64'd1 << CNT_W;

  if (64'(HTotal) > CntRange || 64'(VTotal) > CntRange) begin : g_cnt_w_too_small
    $error("vga_timing_gen: CNT_W=%0d cannot hold H_TOTAL=%0d / V_TOTAL=%0d",
           CNT_W, HTotal, VTotal);
  end

  logic h_last, v_last;
  logic h_active_nxt, v_active_nxt;
  logic v_adv;
  logic line_start_d, frame_start_d;
  logic active_q, line_start_q, frame_start_q;

  // Both axes wrap on the same edge, so a frame is exactly V_TOTAL lines.
  assign v_adv         = i_pix_en & h_last;
  assign line_start_d  = i_pix_en & ~i_restart & h_last;
  assign frame_start_d = line_start_d & v_last;

  vga_axis_timer #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP),
    .POL    (HS_POL),
    .CNT_W  (CNT_W)
  ) u_h_axis (
    .clk        (clk),
    .rst_n      (rst_n),
    .adv        (i_pix_en),
    .restart    (i_restart),
    .count      (o_hcounter),
    .sync       (o_hsync),
    .last       (h_last),
    .active_nxt (h_active_nxt)
  );

  vga_axis_timer #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP),
    .POL    (VS_POL),
    .CNT_W  (CNT_W)
  ) u_v_axis (
    .clk        (clk),
    .rst_n      (rst_n),
    .adv        (v_adv),
    .restart    (i_restart),
    .count      (o_vcounter),
    .sync       (o_vsync),
    .last       (v_last),
    .active_nxt (v_active_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q      <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      active_q      <= h_active_nxt & v_active_nxt;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign o_active      = active_q;
  assign o_line_start  = line_start_q;
  assign o_frame_start = frame_start_q;

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] frame_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_q <= '0;
    end else if (i_restart) begin
      frame_cnt_q <= '0;
    end else if (frame_start_d) begin
      frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  assign o_frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: two small modes (active-low and active-high) against a pixel-index model.
module tb_vga_timing_gen;

  localparam int unsigned H0A = 10, H0F = 2, H0S = 3, H0B = 4;
  localparam int unsigned V0A = 6,  V0F = 1, V0S = 2, V0B = 2;
  localparam int unsigned CW0 = 5;
  localparam int unsigned H1A = 7,  H1F = 0, H1S = 2, H1B = 1;
  localparam int unsigned V1A = 4,  V1F = 0, V1S = 1, V1B = 1;
  localparam int unsigned CW1 = 4;

  typedef struct packed {
    int unsigned ha, hf, hs, hb, va, vf, vs, vb;
    logic        pol;
  } mode_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pix_en = 1'b0;
  logic restart = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  logic [CW0-1:0] hc0, vc0;
  logic [CW1-1:0] hc1, vc1;
  logic           hs0, vs0, act0, ls0, fs0;
  logic           hs1, vs1, act1, ls1, fs1;
`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0]    fc0, fc1;
`endif

  vga_timing_gen #(
    .H_ACTIVE (H0A), .H_FP (H0F), .H_SYNC (H0S), .H_BP (H0B),
    .V_ACTIVE (V0A), .V_FP (V0F), .V_SYNC (V0S), .V_BP (V0B),
    .HS_POL (1'b0), .VS_POL (1'b0), .CNT_W (CW0)
  ) u_dut0 (
    .clk (clk), .rst_n (rst_n), .i_pix_en (pix_en), .i_restart (restart),
    .o_hcounter (hc0), .o_vcounter (vc0), .o_hsync (hs0), .o_vsync (vs0),
    .o_active (act0), .o_line_start (ls0), .o_frame_start (fs0)
`ifdef VGA_TIMING_FRAME_CNT_EN
    , .o_frame_cnt (fc0)
`endif
  );

  vga_timing_gen #(
    .H_ACTIVE (H1A), .H_FP (H1F), .H_SYNC (H1S), .H_BP (H1B),
    .V_ACTIVE (V1A), .V_FP (V1F), .V_SYNC (V1S), .V_BP (V1B),
    .HS_POL (1'b1), .VS_POL (1'b1), .CNT_W (CW1)
  ) u_dut1 (
    .clk (clk), .rst_n (rst_n), .i_pix_en (pix_en), .i_restart (restart),
    .o_hcounter (hc1), .o_vcounter (vc1), .o_hsync (hs1), .o_vsync (vs1),
    .o_active (act1), .o_line_start (ls1), .o_frame_start (fs1)
`ifdef VGA_TIMING_FRAME_CNT_EN
    , .o_frame_cnt (fc1)
`endif
  );

  int unsigned dh[2], dv[2], dfc[2];
  logic        dhs[2], dvs[2], dact[2], dls[2], dfs[2];

  always_comb begin
    dh[0] = 32'(hc0);  dv[0] = 32'(vc0);  dhs[0] = hs0; dvs[0] = vs0;
    dact[0] = act0;    dls[0] = ls0;      dfs[0] = fs0;
    dh[1] = 32'(hc1);  dv[1] = 32'(vc1);  dhs[1] = hs1; dvs[1] = vs1;
    dact[1] = act1;    dls[1] = ls1;      dfs[1] = fs1;
`ifdef VGA_TIMING_FRAME_CNT_EN
    dfc[0] = 32'(fc0); dfc[1] = 32'(fc1);
`else
    dfc[0] = 0;        dfc[1] = 0;
`endif
  end

  function automatic mode_t mode_of(input int k);
    mode_t m;
    if (k == 0) m = '{H0A, H0F, H0S, H0B, V0A, V0F, V0S, V0B, 1'b0};
    else        m = '{H1A, H1F, H1S, H1B, V1A, V1F, V1S, V1B, 1'b1};
    return m;
  endfunction

  function automatic int unsigned htot(input int k);
    mode_t m = mode_of(k);
    return m.ha + m.hf + m.hs + m.hb;
  endfunction

  function automatic int unsigned vtot(input int k);
    mode_t m = mode_of(k);
    return m.va + m.vf + m.vs + m.vb;
  endfunction

  function automatic logic inact(input int k);
    mode_t m = mode_of(k);
    return ~m.pol;
  endfunction

  function automatic logic exp_hs(input int k, input int unsigned h);
    mode_t m = mode_of(k);
    return (h >= m.ha + m.hf && h < m.ha + m.hf + m.hs) ? m.pol : ~m.pol;
  endfunction

  function automatic logic exp_vs(input int k, input int unsigned v);
    mode_t m = mode_of(k);
    return (v >= m.va + m.vf && v < m.va + m.vf + m.vs) ? m.pol : ~m.pol;
  endfunction

  function automatic logic exp_act(input int k, input int unsigned h, input int unsigned v);
    mode_t m = mode_of(k);
    return (h < m.ha) && (v < m.va);
  endfunction

  // Raster position as a single pixel index within the frame.
  function automatic int unsigned next_idx(input int k, input int unsigned h, input int unsigned v);
    return (v * htot(k) + h + 1) % (htot(k) * vtot(k));
  endfunction

  int unsigned mh[2], mv[2], mfc[2];
  logic        mls[2], mfs[2];

  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        mh[k] <= htot(k) - 1; mv[k] <= vtot(k) - 1;
        mls[k] <= 1'b0; mfs[k] <= 1'b0; mfc[k] <= 0;
      end else if (restart) begin
        mh[k] <= htot(k) - 1; mv[k] <= vtot(k) - 1;
        mls[k] <= 1'b0; mfs[k] <= 1'b0; mfc[k] <= 0;
      end else if (pix_en) begin
        mh[k]  <= next_idx(k, mh[k], mv[k]) % htot(k);
        mv[k]  <= next_idx(k, mh[k], mv[k]) / htot(k);
        mls[k] <= (next_idx(k, mh[k], mv[k]) % htot(k)) == 0;
        mfs[k] <= next_idx(k, mh[k], mv[k]) == 0;
        if (next_idx(k, mh[k], mv[k]) == 0) mfc[k] <= (mfc[k] + 1) % 65536;
      end else begin
        mls[k] <= 1'b0; mfs[k] <= 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; pix_en = 1'b0; restart = 1'b0;
    repeat (3) tick();
    for (int k = 0; k < 2; k++) begin
      checks += 7;
      if (dh[k] !== htot(k) - 1) begin errors++; $display("FAIL reset_h[%0d]: got %0d want %0d", k, dh[k], htot(k) - 1); end
      if (dv[k] !== vtot(k) - 1) begin errors++; $display("FAIL reset_v[%0d]: got %0d want %0d", k, dv[k], vtot(k) - 1); end
      if (dhs[k] !== inact(k)) begin errors++; $display("FAIL reset_hsync[%0d]: got %b want %b", k, dhs[k], inact(k)); end
      if (dvs[k] !== inact(k)) begin errors++; $display("FAIL reset_vsync[%0d]: got %b want %b", k, dvs[k], inact(k)); end
      if (dact[k] !== 1'b0) begin errors++; $display("FAIL reset_active[%0d]: got %b want 0", k, dact[k]); end
      if (dls[k] !== 1'b0) begin errors++; $display("FAIL reset_line_start[%0d]: got %b want 0", k, dls[k]); end
      if (dfs[k] !== 1'b0) begin errors++; $display("FAIL reset_frame_start[%0d]: got %b want 0", k, dfs[k]); end
`ifdef VGA_TIMING_FRAME_CNT_EN
      checks++;
      if (dfc[k] !== 0) begin errors++; $display("FAIL reset_frame_cnt[%0d]: got %0d want 0", k, dfc[k]); end
`endif
    end
  endtask

  task automatic test_first_tick();
    rst_n = 1'b1;
    tick();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (dh[k] !== htot(k) - 1) begin errors++; $display("FAIL idle_h[%0d]: got %0d want %0d", k, dh[k], htot(k) - 1); end
    end
    pix_en = 1'b1;
    tick();
    for (int k = 0; k < 2; k++) begin
      checks += 5;
      if (dh[k] !== 0 || dv[k] !== 0) begin errors++; $display("FAIL first_pos[%0d]: got (%0d,%0d) want (0,0)", k, dh[k], dv[k]); end
      if (dls[k] !== 1'b1) begin errors++; $display("FAIL first_line_start[%0d]: got %b want 1", k, dls[k]); end
      if (dfs[k] !== 1'b1) begin errors++; $display("FAIL first_frame_start[%0d]: got %b want 1", k, dfs[k]); end
      if (dact[k] !== 1'b1) begin errors++; $display("FAIL first_active[%0d]: got %b want 1", k, dact[k]); end
      if (dhs[k] !== inact(k)) begin errors++; $display("FAIL first_hsync[%0d]: got %b want %b", k, dhs[k], inact(k)); end
`ifdef VGA_TIMING_FRAME_CNT_EN
      checks++;
      if (dfc[k] !== 1) begin errors++; $display("FAIL first_frame_cnt[%0d]: got %0d want 1", k, dfc[k]); end
`endif
    end
  endtask

  task automatic test_frame_timing();
    pix_en = 1'b1; restart = 1'b0;
    for (int k = 0; k < 2; k++) begin
      mode_t m = mode_of(k);
      int unsigned ftot = htot(k) * vtot(k);
      int unsigned budget = 0;
      int unsigned n_act = 0, n_hs = 0, n_vs = 0, n_ls = 0, n_fs = 0, last_ls = 0;
      while (dfs[k] !== 1'b1 && budget < 2 * ftot) begin tick(); budget++; end
      checks++;
      if (dfs[k] !== 1'b1) begin
        errors++; $display("FAIL frame_align[%0d]: no frame_start within %0d clks", k, 2 * ftot);
      end else begin
        for (int c = 0; c < int'(ftot); c++) begin
          if (dact[k] === 1'b1) n_act++;
          if (dhs[k] !== inact(k)) n_hs++;
          if (dvs[k] !== inact(k)) n_vs++;
          if (dfs[k] === 1'b1) n_fs++;
          if (dls[k] === 1'b1) begin
            if (n_ls != 0) begin
              checks++;
              if (c - last_ls != htot(k)) begin errors++; $display("FAIL line_period[%0d]: got %0d want %0d", k, c - last_ls, htot(k)); end
            end
            n_ls++; last_ls = c;
          end
          if ((dh[k] == m.ha && dv[k] == 0) || (dh[k] == 0 && dv[k] == m.va)) begin
            checks++;
            if (dact[k] !== 1'b0) begin errors++; $display("FAIL active_edge[%0d]: (%0d,%0d) got %b want 0", k, dh[k], dv[k], dact[k]); end
          end
          tick();
        end
        checks += 6;
        if (dfs[k] !== 1'b1 || dh[k] !== 0 || dv[k] !== 0) begin errors++; $display("FAIL frame_period[%0d]: after %0d clks fs=%b pos=(%0d,%0d) want 1 (0,0)", k, ftot, dfs[k], dh[k], dv[k]); end
        if (n_act != m.ha * m.va) begin errors++; $display("FAIL active_count[%0d]: got %0d want %0d", k, n_act, m.ha * m.va); end
        if (n_hs != m.hs * vtot(k)) begin errors++; $display("FAIL hsync_count[%0d]: got %0d want %0d", k, n_hs, m.hs * vtot(k)); end
        if (n_vs != m.vs * htot(k)) begin errors++; $display("FAIL vsync_count[%0d]: got %0d want %0d", k, n_vs, m.vs * htot(k)); end
        if (n_ls != vtot(k)) begin errors++; $display("FAIL line_count[%0d]: got %0d want %0d", k, n_ls, vtot(k)); end
        if (n_fs != 1) begin errors++; $display("FAIL frame_count[%0d]: got %0d want 1", k, n_fs); end
      end
    end
  endtask

  task automatic test_sparse();
    int unsigned ph[2], pv[2];
    logic        phs[2], pvs[2], pact[2];
    int          last_ls[2];
    restart = 1'b0;
    last_ls[0] = -1; last_ls[1] = -1;
    for (int c = 0; c < int'(8 * htot(0)); c++) begin
      ph = dh; pv = dv; phs = dhs; pvs = dvs; pact = dact;
      pix_en = (c % 4 == 0);
      tick();
      for (int k = 0; k < 2; k++) begin
        if (!pix_en) begin
          checks++;
          if (dh[k] !== ph[k] || dv[k] !== pv[k] || dhs[k] !== phs[k] || dvs[k] !== pvs[k] ||
              dact[k] !== pact[k] || dls[k] !== 1'b0 || dfs[k] !== 1'b0) begin
            errors++;
            $display("FAIL sparse_hold[%0d]: got (%0d,%0d) hs=%b vs=%b act=%b ls=%b fs=%b want (%0d,%0d) hs=%b vs=%b act=%b ls=0 fs=0",
                     k, dh[k], dv[k], dhs[k], dvs[k], dact[k], dls[k], dfs[k], ph[k], pv[k], phs[k], pvs[k], pact[k]);
          end
        end else begin
          checks++;
          if (dh[k] !== mh[k] || dv[k] !== mv[k]) begin errors++; $display("FAIL sparse_pos[%0d]: got (%0d,%0d) want (%0d,%0d)", k, dh[k], dv[k], mh[k], mv[k]); end
        end
        if (dls[k] === 1'b1) begin
          if (last_ls[k] >= 0) begin
            checks++;
            if (c - last_ls[k] != int'(4 * htot(k))) begin errors++; $display("FAIL sparse_line_period[%0d]: got %0d want %0d", k, c - last_ls[k], 4 * htot(k)); end
          end
          last_ls[k] = c;
        end
      end
    end
  endtask

  task automatic test_restart();
    int unsigned budget = 0;
    pix_en = 1'b1; restart = 1'b0;
    while (!(dh[0] == 5 && dv[0] == 3) && budget < 2 * htot(0) * vtot(0)) begin tick(); budget++; end
    checks++;
    if (!(dh[0] == 5 && dv[0] == 3)) begin errors++; $display("FAIL restart_reach: got (%0d,%0d) want (5,3)", dh[0], dv[0]); end
    restart = 1'b1;
    tick();
    restart = 1'b0;
    for (int k = 0; k < 2; k++) begin
      checks += 5;
      if (dh[k] !== htot(k) - 1 || dv[k] !== vtot(k) - 1) begin errors++; $display("FAIL restart_pos[%0d]: got (%0d,%0d) want (%0d,%0d)", k, dh[k], dv[k], htot(k) - 1, vtot(k) - 1); end
      if (dhs[k] !== inact(k)) begin errors++; $display("FAIL restart_hsync[%0d]: got %b want %b", k, dhs[k], inact(k)); end
      if (dvs[k] !== inact(k)) begin errors++; $display("FAIL restart_vsync[%0d]: got %b want %b", k, dvs[k], inact(k)); end
      if (dact[k] !== 1'b0) begin errors++; $display("FAIL restart_active[%0d]: got %b want 0", k, dact[k]); end
      if (dls[k] !== 1'b0 || dfs[k] !== 1'b0) begin errors++; $display("FAIL restart_strobes[%0d]: got ls=%b fs=%b want 0 0", k, dls[k], dfs[k]); end
`ifdef VGA_TIMING_FRAME_CNT_EN
      checks++;
      if (dfc[k] !== 0) begin errors++; $display("FAIL restart_frame_cnt[%0d]: got %0d want 0", k, dfc[k]); end
`endif
    end
    tick();
    for (int k = 0; k < 2; k++) begin
      checks += 2;
      if (dh[k] !== 0 || dv[k] !== 0) begin errors++; $display("FAIL restart_next_pos[%0d]: got (%0d,%0d) want (0,0)", k, dh[k], dv[k]); end
      if (dfs[k] !== 1'b1) begin errors++; $display("FAIL restart_frame_start[%0d]: got %b want 1", k, dfs[k]); end
`ifdef VGA_TIMING_FRAME_CNT_EN
      checks++;
      if (dfc[k] !== 1) begin errors++; $display("FAIL restart_frame_cnt1[%0d]: got %0d want 1", k, dfc[k]); end
`endif
    end
  endtask

  task automatic test_async_reset();
    int unsigned budget = 0;
    int unsigned n0 = 0, n1 = 0;
    pix_en = 1'b1; restart = 1'b0;
    while (!(dh[0] == 3 && dv[0] == 2) && budget < 2 * htot(0) * vtot(0)) begin tick(); budget++; end
    checks++;
    if (!(dh[0] == 3 && dv[0] == 2)) begin errors++; $display("FAIL areset_reach: got (%0d,%0d) want (3,2)", dh[0], dv[0]); end
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      checks += 3;
      if (dh[k] !== htot(k) - 1 || dv[k] !== vtot(k) - 1) begin errors++; $display("FAIL areset_pos[%0d]: got (%0d,%0d) want (%0d,%0d)", k, dh[k], dv[k], htot(k) - 1, vtot(k) - 1); end
      if (dact[k] !== 1'b0 || dls[k] !== 1'b0 || dfs[k] !== 1'b0) begin errors++; $display("FAIL areset_flags[%0d]: got act=%b ls=%b fs=%b want 0 0 0", k, dact[k], dls[k], dfs[k]); end
      if (dhs[k] !== inact(k) || dvs[k] !== inact(k)) begin errors++; $display("FAIL areset_syncs[%0d]: got hs=%b vs=%b want %b", k, dhs[k], dvs[k], inact(k)); end
    end
    tick();
    rst_n = 1'b1;
    budget = 0;
    while (n0 < 3 && budget < 4 * htot(0) * vtot(0)) begin
      tick(); budget++;
      if (dfs[0] === 1'b1) n0++;
      if (dfs[1] === 1'b1) n1++;
    end
    checks++;
    if (n0 != 3) begin errors++; $display("FAIL areset_frames: got %0d frame_starts want 3", n0); end
`ifdef VGA_TIMING_FRAME_CNT_EN
    checks += 2;
    if (dfc[0] !== 3) begin errors++; $display("FAIL areset_frame_cnt[0]: got %0d want 3", dfc[0]); end
    if (dfc[1] !== n1) begin errors++; $display("FAIL areset_frame_cnt[1]: got %0d want %0d", dfc[1], n1); end
`endif
  endtask

  task automatic test_random();
    rst_n = 1'b1;
    for (int c = 0; c < 2000; c++) begin
      pix_en  = ($urandom_range(0, 3) != 0);
      restart = ($urandom_range(0, 149) == 0);
      tick();
      for (int k = 0; k < 2; k++) begin
        checks += 6;
        if (dh[k] !== mh[k] || dv[k] !== mv[k]) begin errors++; $display("FAIL rand_pos[%0d] c=%0d: got (%0d,%0d) want (%0d,%0d)", k, c, dh[k], dv[k], mh[k], mv[k]); end
        if (dhs[k] !== exp_hs(k, mh[k])) begin errors++; $display("FAIL rand_hsync[%0d] c=%0d: got %b want %b", k, c, dhs[k], exp_hs(k, mh[k])); end
        if (dvs[k] !== exp_vs(k, mv[k])) begin errors++; $display("FAIL rand_vsync[%0d] c=%0d: got %b want %b", k, c, dvs[k], exp_vs(k, mv[k])); end
        if (dact[k] !== exp_act(k, mh[k], mv[k])) begin errors++; $display("FAIL rand_active[%0d] c=%0d: got %b want %b", k, c, dact[k], exp_act(k, mh[k], mv[k])); end
        if (dls[k] !== mls[k]) begin errors++; $display("FAIL rand_line_start[%0d] c=%0d: got %b want %b", k, c, dls[k], mls[k]); end
        if (dfs[k] !== mfs[k]) begin errors++; $display("FAIL rand_frame_start[%0d] c=%0d: got %b want %b", k, c, dfs[k], mfs[k]); end
`ifdef VGA_TIMING_FRAME_CNT_EN
        checks++;
        if (dfc[k] !== mfc[k]) begin errors++; $display("FAIL rand_frame_cnt[%0d] c=%0d: got %0d want %0d", k, c, dfc[k], mfc[k]); end
`endif
      end
    end
    pix_en = 1'b0; restart = 1'b0;
  endtask

  initial begin
    test_reset();
    test_first_tick();
    test_frame_timing();
    test_sparse();
    test_restart();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
